seven_seg_scan_driver: RTL and testbench



---
 rtl/seven_seg_scan_driver_if.sv | 24 ++
 rtl/seven_seg_scan_driver.sv | 150 +++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_driver_if.sv
// Display-side bus of the seven-segment scan driver: the shadow-load inputs and
// the registered pin outputs, grouped so the driver and its source share one port.
interface seven_seg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    scan_tick;

    modport master (
        output value, load, digit_en, dp_in,
        input  seg, dp, an, scan_tick
    );

    modport slave (
        input  value, load, digit_en, dp_in,
        output seg, dp, an, scan_tick
    );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with shadowed hex data.
// Optional macro SEVEN_SEG_LZB_EN enables leading-zero blanking.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    seven_seg_scan_driver_if.slave bus
);
    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
            $fatal(1, "seven_seg_scan_driver: NUM_DIGITS must be 1..8");
        end
        if (REFRESH_DIV < 1) begin : g_bad_div
            $fatal(1, "seven_seg_scan_driver: REFRESH_DIV must be >= 1");
        end
    endgenerate

    logic [PRE_W-1:0]          prescaler_reg;
    logic [PRE_W-1:0]          prescaler_next;
    logic [IDX_W-1:0]          index_reg;
    logic [IDX_W-1:0]          index_next;
    logic                      wrap;
    logic [4*NUM_DIGITS-1:0]   shadow_value_reg;
    logic [NUM_DIGITS-1:0]     shadow_en_reg;
    logic [NUM_DIGITS-1:0]     shadow_dp_reg;
    logic [6:0]                seg_reg;
    logic [6:0]                seg_next;
    logic                      dp_reg;
    logic                      dp_next;
    logic [NUM_DIGITS-1:0]     an_reg;
    logic [NUM_DIGITS-1:0]     an_next;
    logic                      scan_tick_reg;
    logic [NUM_DIGITS-1:0]     sel;
    logic [NUM_DIGITS-1:0]     lzb_mask;
    logic [NUM_DIGITS-1:0]     eff_en;
    logic [3:0]                nib_masked [NUM_DIGITS];
    logic [3:0]                cur_nib;
    logic                      cur_en;
    logic                      cur_dp;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Refresh prescaler and digit index
    always_comb begin
        wrap           = (prescaler_reg == PRE_LAST);
        prescaler_next = prescaler_reg + 1'b1;
        index_next     = index_reg;
        if (wrap) begin
            prescaler_next = '0;
            index_next     = (index_reg == IDX_LAST) ? '0 : index_reg + 1'b1;
        end
    end

    // One-hot digit select; the selected nibble is an OR of masked nibbles
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign sel[gi]        = (index_reg == IDX_W'(gi));
            assign nib_masked[gi] = shadow_value_reg[4*gi +: 4] & {4{sel[gi]}};
        end
    endgenerate

`ifdef SEVEN_SEG_LZB_EN
    // A digit above 0 is blanked while it and every higher nibble are zero
    always_comb begin
        logic all_zero;
        lzb_mask = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            all_zero    = all_zero & (shadow_value_reg[4*i +: 4] == 4'h0);
            lzb_mask[i] = all_zero;
        end
    end
`else
    assign lzb_mask = '0;
`endif

    always_comb begin
        cur_nib = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            cur_nib = cur_nib | nib_masked[i];
        end
        eff_en   = shadow_en_reg & ~lzb_mask;
        cur_en   = |(sel & eff_en);
        cur_dp   = |(sel & shadow_dp_reg);
        an_next  = ~(sel & eff_en);
        seg_next = cur_en ? hex_to_seg(cur_nib) : 7'b1111111;
        dp_next  = ~(cur_en & cur_dp);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_reg    <= '0;
            index_reg        <= '0;
            scan_tick_reg    <= 1'b0;
            shadow_value_reg <= '0;
            shadow_en_reg    <= '0;
            shadow_dp_reg    <= '0;
            seg_reg          <= 7'b1111111;
            dp_reg           <= 1'b1;
            an_reg           <= '1;
        end else begin
            prescaler_reg <= prescaler_next;
            index_reg     <= index_next;
            scan_tick_reg <= wrap;
            if (bus.load) begin
                shadow_value_reg <= bus.value;
                shadow_en_reg    <= bus.digit_en;
                shadow_dp_reg    <= bus.dp_in;
            end
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
            an_reg  <= an_next;
        end
    end

    assign bus.seg       = seg_reg;
    assign bus.dp        = dp_reg;
    assign bus.an        = an_reg;
    assign bus.scan_tick = scan_tick_reg;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: a 4-digit / divide-by-4 instance and
// a 1-digit / divide-by-1 instance, each output compared against hand-derived values.
module tb_seven_seg_scan_driver;
    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    seven_seg_scan_driver_if #(.NUM_DIGITS(4)) bus_a ();
    seven_seg_scan_driver_if #(.NUM_DIGITS(1)) bus_b ();

    seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (bus_a)
    );

    seven_seg_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(1)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                           input logic dp_e, input logic tick_e);
        check({tag, ".an"},   16'(bus_a.an),        16'(an_e));
        check({tag, ".seg"},  16'(bus_a.seg),       16'(seg_e));
        check({tag, ".dp"},   16'(bus_a.dp),        16'(dp_e));
        check({tag, ".tick"}, 16'(bus_a.scan_tick), 16'(tick_e));
    endtask

    initial begin
        logic [6:0] seg_tab [4];
        logic [3:0] en_tab;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        int         d;

        reset_a = 1'b1;
        reset_b = 1'b1;
        bus_a.value = '0; bus_a.load = 1'b0; bus_a.digit_en = '0; bus_a.dp_in = '0;
        bus_b.value = '0; bus_b.load = 1'b0; bus_b.digit_en = '0; bus_b.dp_in = '0;

        // Reset held three cycles
        for (int r = 0; r < 3; r++) begin
            step();
            check_a("reset", 4'b1111, 7'b1111111, 1'b1, 1'b0);
        end
        check("b_reset.tick", 16'(bus_b.scan_tick), 16'd0);
        check("b_reset.an",   16'(bus_b.an),        16'd1);

        // Load 12AF, all digits on, dp on digit 2
        reset_a = 1'b0;
        bus_a.value = 16'h12AF; bus_a.digit_en = 4'b1111; bus_a.dp_in = 4'b0100; bus_a.load = 1'b1;
        step();
        bus_a.load = 1'b0;
        check_a("load_latency", 4'b1111, 7'b1111111, 1'b1, 1'b0);
        step();
        check_a("first_digit", 4'b1110, 7'b0111000, 1'b1, 1'b0);
        step();
        step();
        check_a("first_tick", 4'b1110, 7'b0111000, 1'b1, 1'b1);

        seg_tab[0] = 7'b0111000; seg_tab[1] = 7'b0001000;
        seg_tab[2] = 7'b0010010; seg_tab[3] = 7'b1001111;
        for (int k = 0; k < 16; k++) begin
            step();
            d = (1 + k / 4) % 4;
            an_e = 4'(~(4'b0001 << d));
            check_a($sformatf("frame_12AF[%0d]", k), an_e, seg_tab[d], (d == 2) ? 1'b0 : 1'b1,
                    (k % 4 == 3) ? 1'b1 : 1'b0);
        end

        // Digits 1 and 3 enabled, value 8888
        bus_a.value = 16'h8888; bus_a.digit_en = 4'b1010; bus_a.dp_in = 4'b0000; bus_a.load = 1'b1;
        step();
        bus_a.load = 1'b0;
        step();
        check_a("en1010_first", 4'b1101, 7'b0000000, 1'b1, 1'b0);
        step();
        step();
        en_tab = 4'b1010;
        for (int k = 0; k < 16; k++) begin
            step();
            d = (2 + k / 4) % 4;
            an_e  = en_tab[d] ? 4'(~(4'b0001 << d)) : 4'b1111;
            seg_e = en_tab[d] ? 7'b0000000 : 7'b1111111;
            check_a($sformatf("frame_8888[%0d]", k), an_e, seg_e, 1'b1, (k % 4 == 3) ? 1'b1 : 1'b0);
        end

        // Load 0003 on the same edge as a scan tick
        step();
        step();
        step();
        bus_a.value = 16'h0003; bus_a.digit_en = 4'b1111; bus_a.dp_in = 4'b0000; bus_a.load = 1'b1;
        step();
        bus_a.load = 1'b0;
        check_a("load_on_tick", 4'b1111, 7'b1111111, 1'b1, 1'b1);
        for (int k = 0; k < 16; k++) begin
            step();
            d = (3 + k / 4) % 4;
            if (d == 0) begin
                an_e = 4'b1110; seg_e = 7'b0000110;
            end else begin
`ifdef SEVEN_SEG_LZB_EN
                an_e = 4'b1111; seg_e = 7'b1111111;
`else
                an_e = 4'(~(4'b0001 << d)); seg_e = 7'b0000001;
`endif
            end
            check_a($sformatf("frame_0003[%0d]", k), an_e, seg_e, 1'b1, (k % 4 == 3) ? 1'b1 : 1'b0);
        end

        // Advance to mid-slot of digit 2, then reset
        for (int k = 0; k < 13; k++) step();
`ifdef SEVEN_SEG_LZB_EN
        check("mid_slot2.an", 16'(bus_a.an), 16'(4'b1111));
`else
        check("mid_slot2.an", 16'(bus_a.an), 16'(4'b1011));
`endif
        reset_a = 1'b1;
        step();
        check_a("mid_reset", 4'b1111, 7'b1111111, 1'b1, 1'b0);
        reset_a = 1'b0;
        bus_a.value = 16'h0005; bus_a.digit_en = 4'b0001; bus_a.dp_in = 4'b0001; bus_a.load = 1'b1;
        step();
        bus_a.load = 1'b0;
        check_a("post_reset0", 4'b1111, 7'b1111111, 1'b1, 1'b0);
        step();
        check_a("post_reset1", 4'b1110, 7'b0100100, 1'b0, 1'b0);
        step();
        check_a("post_reset2", 4'b1110, 7'b0100100, 1'b0, 1'b0);
        step();
        check_a("post_reset3", 4'b1110, 7'b0100100, 1'b0, 1'b1);
        step();
        check_a("post_reset4", 4'b1111, 7'b1111111, 1'b1, 1'b0);

        // Single digit, divide-by-1 instance
        reset_b = 1'b0;
        bus_b.value = 4'h9; bus_b.digit_en = 1'b1; bus_b.dp_in = 1'b1; bus_b.load = 1'b1;
        step();
        check("b_f1.tick", 16'(bus_b.scan_tick), 16'd1);
        check("b_f1.an",   16'(bus_b.an),        16'd1);
        check("b_f1.seg",  16'(bus_b.seg),       16'(7'b1111111));
        bus_b.value = 4'hC;
        step();
        check("b_f2.tick", 16'(bus_b.scan_tick), 16'd1);
        check("b_f2.an",   16'(bus_b.an),        16'd0);
        check("b_f2.seg",  16'(bus_b.seg),       16'(7'b0000100));
        check("b_f2.dp",   16'(bus_b.dp),        16'd0);
        bus_b.load = 1'b0;
        step();
        check("b_f3.seg",  16'(bus_b.seg),       16'(7'b0110001));
        bus_b.value = 4'h0;
        step();
        check("b_f4.seg",  16'(bus_b.seg),       16'(7'b0110001));
        check("b_f4.tick", 16'(bus_b.scan_tick), 16'd1);
        check("b_f4.an",   16'(bus_b.an),        16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
